// File: rtl/dcpu_bus_arbiter_if.sv
// dcpu_bus_arbiter_if: two-master/one-slave dcpu memory bus bundle.
// Ports: i_m0_*/i_m1_* come from the masters and o_m0_*/o_m1_* go back to them;
// o_s_* drive the shared slave and i_s_* come from it; o_grant is the one-hot grant {m1,m0}.
// Modport master is the arbiter's view (it masters the slave bus); modport slave is the environment's view.
interface dcpu_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] i_m0_addr, i_m1_addr, o_s_addr;
  logic [DW-1:0] i_m0_dat, i_m1_dat, o_m0_dat, o_m1_dat, o_s_dat, i_s_dat;
  logic i_m0_we, i_m0_cs, o_m0_ack, o_m0_err;
  logic i_m1_we, i_m1_cs, o_m1_ack, o_m1_err;
  logic o_s_we, o_s_cs, i_s_ack;
  logic [1:0] o_grant;
  modport master (
    input  i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
    input  i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
    input  i_s_dat, i_s_ack,
    output o_m0_dat, o_m0_ack, o_m0_err,
    output o_m1_dat, o_m1_ack, o_m1_err,
    output o_s_addr, o_s_dat, o_s_we, o_s_cs, o_grant
  );
  modport slave (
    output i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
    output i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
    output i_s_dat, i_s_ack,
    input  o_m0_dat, o_m0_ack, o_m0_err,
    input  o_m1_dat, o_m1_ack, o_m1_err,
    input  o_s_addr, o_s_dat, o_s_we, o_s_cs, o_grant
  );
endinterface

// File: rtl/dcpu_bus_arbiter.sv
// dcpu_bus_arbiter: round-robin two-master arbiter for one dcpu bus slave, with a stall watchdog.
// Ports: i_clk rising-edge clock; i_reset_n synchronous active-low reset;
// io_bus carries both master ports, the slave port and the one-hot grant.
module dcpu_bus_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input logic                i_clk,
  input logic                i_reset_n,
  dcpu_bus_arbiter_if.master io_bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t r_state;
  logic r_last;
  logic [TW-1:0] r_cnt;
  logic w_g0, w_g1, w_cs, w_to, w_ack, w_scs;
  always_comb begin
    w_g0  = r_state == GNT0;
    w_g1  = r_state == GNT1;
    w_cs  = w_g0 ? io_bus.i_m0_cs : w_g1 ? io_bus.i_m1_cs : 1'b0;
    // watchdog fires on the TIMEOUT-th grant cycle unless the slave acks in that same cycle
    w_to  = TIMEOUT != 0 && w_cs && !io_bus.i_s_ack && r_cnt == TW'(TIMEOUT - 1);
    w_ack = w_cs && (io_bus.i_s_ack || w_to);
    w_scs = w_cs && !w_to;
  end
  assign io_bus.o_s_cs   = w_scs;
  assign io_bus.o_s_we   = w_scs && (w_g0 ? io_bus.i_m0_we : io_bus.i_m1_we);
  assign io_bus.o_s_addr = w_g0 ? io_bus.i_m0_addr : w_g1 ? io_bus.i_m1_addr : AW'(0);
  assign io_bus.o_s_dat  = w_g0 ? io_bus.i_m0_dat : w_g1 ? io_bus.i_m1_dat : DW'(0);
  assign io_bus.o_m0_dat = w_g0 ? io_bus.i_s_dat : DW'(0);
  assign io_bus.o_m1_dat = w_g1 ? io_bus.i_s_dat : DW'(0);
  assign io_bus.o_m0_ack = w_g0 && w_ack;
  assign io_bus.o_m1_ack = w_g1 && w_ack;
  assign io_bus.o_m0_err = w_g0 && w_to;
  assign io_bus.o_m1_err = w_g1 && w_to;
  assign io_bus.o_grant  = {w_g1, w_g0};
  // every grant returns to IDLE, which guarantees one idle cycle between transactions
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      if (io_bus.i_m0_cs && (!io_bus.i_m1_cs || r_last)) begin
        r_state <= GNT0;
        r_last  <= 1'b0;
      end else if (io_bus.i_m1_cs) begin
        r_state <= GNT1;
        r_last  <= 1'b1;
      end
    end else if (!w_cs || w_ack)
      r_state <= IDLE;
    else if (TIMEOUT != 0 && r_cnt != '1)
      r_cnt <= r_cnt + 1'b1;
endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// tb_dcpu_bus_arbiter: scoreboard bench for dcpu_bus_arbiter with a latency-by-address slave model.
module tb_dcpu_bus_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcpu_bus_arbiter_if #(.AW(16), .DW(16)) bus ();
  dcpu_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT(TO), .TW(6)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .io_bus(bus)
  );

  typedef struct {
    logic [15:0] dat;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[2][$];
  int total = 0, bad = 0;
  int done[2] = '{0, 0};
  logic [15:0] a[2] = '{16'h0, 16'h0};
  logic [15:0] wd[2] = '{16'h0, 16'h0};
  logic we[2] = '{1'b0, 1'b0};
  logic cs[2] = '{1'b0, 1'b0};

  assign bus.i_m0_addr = a[0];
  assign bus.i_m0_dat  = wd[0];
  assign bus.i_m0_we   = we[0];
  assign bus.i_m0_cs   = cs[0];
  assign bus.i_m1_addr = a[1];
  assign bus.i_m1_dat  = wd[1];
  assign bus.i_m1_we   = we[1];
  assign bus.i_m1_cs   = cs[1];

  // slave model: read data and ack latency (grant cycles before ack) are functions of the address
  function automatic logic [15:0] rdat(logic [15:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A3C;
  endfunction
  function automatic int lat(logic [15:0] x);
    return int'(x[5:3]);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  int gcs = 0;
  logic [1:0] pg_s = 2'b00;
  always @(posedge clk) begin
    #2;
    gcs = (bus.o_grant != 2'b00 && pg_s != 2'b00) ? gcs + 1 : 0;
    pg_s = bus.o_grant;
    bus.i_s_ack = bus.o_grant != 2'b00 && gcs == lat(a[bus.o_grant[1]]);
    bus.i_s_dat = bus.o_grant != 2'b00 ? rdat(a[bus.o_grant[1]]) : 16'h0;
  end

  // monitor: arbitration model (round robin over requests seen in the idle cycle) plus response scoreboard
  logic [1:0] pg = 2'b00, g;
  logic pc0 = 1'b0, pc1 = 1'b0, pack = 1'b0, m_last = 1'b1, ecs;
  logic [1:0] acks, errs;
  logic [15:0] mdat[2];
  int gc = 0, w, k;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pg = 2'b00; pc0 = 1'b0; pc1 = 1'b0; pack = 1'b0; m_last = 1'b1; gc = 0;
    end else begin
      g = bus.o_grant;
      acks = {bus.o_m1_ack, bus.o_m0_ack};
      errs = {bus.o_m1_err, bus.o_m0_err};
      mdat[0] = bus.o_m0_dat;
      mdat[1] = bus.o_m1_dat;
      if (pg == 2'b00) begin
        w = (pc0 && pc1) ? (m_last ? 0 : 1) : pc0 ? 0 : pc1 ? 1 : -1;
        chk("grant_start", 64'(g), w < 0 ? 64'd0 : 64'(1 << w));
        if (w >= 0) m_last = w[0];
        gc = 0;
      end else begin
        if (pack) chk("idle_after_ack", 64'(g), 64'd0);
        else chk("grant_hold", 64'(g), 64'(pg));
        gc++;
      end
      if (g == 2'b00)
        chk("idle_outputs", 64'(|{bus.o_s_cs, bus.o_s_we, bus.o_s_addr, bus.o_s_dat, acks, errs, mdat[0], mdat[1]}), 64'd0);
      else begin
        k = g[1] ? 1 : 0;
        ecs = !(gc == TO - 1 && lat(a[k]) >= TO);
        chk("s_addr", 64'(bus.o_s_addr), 64'(a[k]));
        chk("s_dat", 64'(bus.o_s_dat), 64'(wd[k]));
        chk("s_cs", 64'(bus.o_s_cs), 64'(ecs));
        chk("s_we", 64'(bus.o_s_we), 64'(we[k] && ecs));
        chk("other_quiet", 64'({acks[1-k], errs[1-k], mdat[1-k]}), 64'd0);
        if (!acks[k]) chk("err_without_ack", 64'(errs[k]), 64'd0);
        else if (q[k].size() == 0) chk("unexpected_ack", 64'(k + 1), 64'd0);
        else begin
          e = q[k].pop_front();
          chk("m_dat", 64'(mdat[k]), 64'(e.dat));
          chk("m_err", 64'(errs[k]), 64'(e.err));
          chk("ack_cycle", 64'(gc), 64'(e.cyc));
          done[k]++;
        end
      end
      pack = |acks;
      pc0 = bus.i_m0_cs;
      pc1 = bus.i_m1_cs;
      pg = g;
    end
  end

  task automatic req(int m, logic [15:0] ad, logic wr, logic [15:0] d);
    exp_t x;
    x.dat = rdat(ad);
    x.err = lat(ad) >= TO;
    x.cyc = lat(ad) >= TO ? TO - 1 : lat(ad);
    q[m].push_back(x);
    a[m] = ad; we[m] = wr; wd[m] = d; cs[m] = 1'b1;
  endtask

  task automatic wait_done(int m, int target);
    int n = 0;
    while (done[m] < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (done[m] < target) chk("ack_wait", 64'(done[m]), 64'(target));
    cs[m] = 1'b0;
  endtask

  task automatic xact(int m, logic [15:0] ad, logic wr, logic [15:0] d);
    int t = done[m] + 1;
    req(m, ad, wr, d);
    wait_done(m, t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs[0] = 1'b0; cs[1] = 1'b0;
    q[0].delete(); q[1].delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_rand(int m);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      xact(m, 16'($urandom), 1'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n, t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(bus.o_grant), 64'd0);
    chk("rst_outputs", 64'(|{bus.o_s_cs, bus.o_s_we, bus.o_s_addr, bus.o_m0_ack, bus.o_m1_ack, bus.o_m0_err, bus.o_m1_err}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    xact(0, 16'h0010, 1'b0, 16'h0000);
    do_reset();
    fork
      xact(0, 16'h0000, 1'b1, 16'h1111);
      xact(1, 16'h0008, 1'b1, 16'h2222);
    join
    fork
      for (int i = 0; i < 3; i++) xact(0, {10'($urandom), 6'b001000}, 1'($urandom), 16'($urandom));
      for (int i = 0; i < 3; i++) xact(1, {10'($urandom), 6'b001000}, 1'($urandom), 16'($urandom));
    join
    xact(1, 16'h0038, 1'b0, 16'h0000);
    xact(0, 16'h0000, 1'b0, 16'h0000);
    xact(0, 16'h0018, 1'b1, 16'hA5A5);
    xact(1, 16'h0418, 1'b0, 16'h0000);
    do_reset();
    t0 = done[0];
    req(0, 16'h0038, 1'b0, 16'h0000);
    n = 0;
    while (bus.o_grant != 2'b01 && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_test_grant", 64'(bus.o_grant), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre", 64'({bus.o_grant, bus.o_s_cs, bus.o_m0_ack, bus.o_m0_err}), 64'b01100);
    @(negedge clk);
    chk("rst_mid_cs", 64'(bus.o_s_cs), 64'd0);
    chk("rst_mid_grant", 64'(bus.o_grant), 64'd0);
    chk("rst_mid_ack", 64'({bus.o_m0_ack, bus.o_m0_err, bus.o_m1_ack, bus.o_m1_err}), 64'd0);
    chk("rst_mid_no_done", 64'(done[0]), 64'(t0));
    q[0].delete(); q[1].delete();
    t0 = done[0] + 1;
    n = done[1] + 1;
    req(0, 16'h0010, 1'b0, 16'h0000);
    req(1, 16'h0000, 1'b1, 16'h3333);
    @(posedge clk); #1 rst_n = 1'b1;
    fork
      wait_done(0, t0);
      wait_done(1, n);
    join
    fork
      run_rand(0);
      run_rand(1);
    join
    repeat (3) @(posedge clk);
    chk("queues_empty", 64'(q[0].size() + q[1].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
